tinv_bus_arbiter: RTL and testbench

Round-robin arbiter sharing one tristate bus, built from TINV cells, among N requesters. Drives a complementary EN/nEN pair per requester straight into the TINV enables. Inserts mandatory dead (turnaround) cycles between owners, so two discrete drivers never fight on the bus. Sits beside the register-file/ALU result bus; requesters are the datapath units that write to it.

---
 rtl/tinv_bus_arbiter_pkg.sv | 25 ++
 rtl/tinv_bus_arbiter_if.sv | 23 ++
 rtl/tinv_bus_arbiter_rr_pick.sv | 33 +++
 rtl/tinv_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_tinv_bus_arbiter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/tinv_bus_arbiter_pkg.sv
// Shared types and limits for the TINV result-bus arbiter.
package tinv_bus_arbiter_pkg;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;
  localparam int TURN_MIN = 1;
  localparam int TURN_MAX = 3;
  localparam int HOLD_MIN = 2;
  localparam int HOLD_MAX = 15;

  // Counter widths sized to the upper limits above.
  localparam int HOLD_W = 4;
  localparam int TURN_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tinv_bus_arbiter_if.sv
// Requester-side bundle: level requests in, one-hot grant and TINV enable pair out.
interface tinv_bus_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int OW = tinv_bus_arbiter_pkg::owner_w(N_REQ);

  logic [N_REQ-1:0] REQ;
  logic [N_REQ-1:0] GNT;
  logic [N_REQ-1:0] EN;
  logic [N_REQ-1:0] nEN;
  logic [OW-1:0]    OWNER;
  logic             BUS_IDLE;

  modport master (
    input  REQ,
    output GNT, EN, nEN, OWNER, BUS_IDLE
  );

  modport slave (
    output REQ,
    input  GNT, EN, nEN, OWNER, BUS_IDLE
  );
endinterface

// File: rtl/tinv_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module tinv_bus_arbiter_rr_pick
  import tinv_bus_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int OW    = owner_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [OW-1:0]    win_idx,
  output logic             win_vld
);

  logic [OW-1:0] idx;

  // i runs 1..N_REQ so ptr itself is visited last.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = OW'((int'(ptr) + i) % N_REQ);
      if (!win_vld && req[idx]) begin
        win_vld     = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/tinv_bus_arbiter.sv
// Round-robin owner of the shared TINV result bus with enforced dead cycles
// between drivers; EN and nEN come from separate flops so they never overlap.
module tinv_bus_arbiter
  import tinv_bus_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  tinv_bus_arbiter_if.master  bus
);

  localparam int OW = owner_w(N_REQ);

  if (N_REQ < NREQ_MIN || N_REQ > NREQ_MAX) begin : g_bad_nreq
    $error("tinv_bus_arbiter: N_REQ out of range");
  end
  if (TURN_CYCLES < TURN_MIN || TURN_CYCLES > TURN_MAX) begin : g_bad_turn
    $error("tinv_bus_arbiter: TURN_CYCLES out of range");
  end
  if (MAX_HOLD < HOLD_MIN || MAX_HOLD > HOLD_MAX) begin : g_bad_hold
    $error("tinv_bus_arbiter: MAX_HOLD out of range");
  end

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  en_q, nen_q;
  logic              idle_q;
  logic [OW-1:0]     owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;

  logic [N_REQ-1:0]  owner_oh;
  logic              own_req, others_req;
  logic [N_REQ-1:0]  pick_oh;
  logic [OW-1:0]     pick_idx;
  logic              pick_vld;

  // The last owner doubles as the round-robin pointer.
  tinv_bus_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (bus.REQ),
    .ptr     (owner_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  assign owner_oh   = N_REQ'(1) << owner_q;
  assign own_req    = bus.REQ[owner_q];
  assign others_req = |(bus.REQ & ~owner_oh);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_OWN;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          hold_d  = HOLD_W'(1);
        end
      end
      ST_OWN: begin
        if (!own_req || (hold_q == HOLD_W'(MAX_HOLD) && others_req)) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          turn_d  = TURN_W'(1);
        end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_W'(TURN_CYCLES)) begin
          if (pick_vld) begin
            state_d = ST_OWN;
            gnt_d   = pick_oh;
            owner_d = pick_idx;
            hold_d  = HOLD_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      en_q    <= '0;
      nen_q   <= '1;
      idle_q  <= 1'b1;
      owner_q <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      en_q    <= gnt_d;
      nen_q   <= ~gnt_d;
      idle_q  <= ~|gnt_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign bus.GNT      = gnt_q;
  assign bus.EN       = en_q;
  assign bus.nEN      = nen_q;
  assign bus.OWNER    = owner_q;
  assign bus.BUS_IDLE = idle_q;

endmodule

// File: tb/tb_tinv_bus_arbiter.sv
// Directed bench: stimulus queues expected grants, a negedge monitor checks them.
module tb_tinv_bus_arbiter;

  logic CLK = 1'b0;
  logic RST_A, RST_B;
  always #5 CLK = ~CLK;

  tinv_bus_arbiter_if #(.N_REQ(4)) bus_a ();
  tinv_bus_arbiter_if #(.N_REQ(4)) bus_b ();

  tinv_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(1), .MAX_HOLD(8)) dut_a (
    .CLK (CLK), .RST (RST_A), .bus (bus_a));
  tinv_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(3), .MAX_HOLD(8)) dut_b (
    .CLK (CLK), .RST (RST_B), .bus (bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int owner;
    int len;   // EN-high cycles, <=0 means not checked
    int gap;   // dead cycles before this grant, <0 means not checked
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int owner, input int len, input int gap);
    exp_t e;
    e.owner = owner; e.len = len; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_en_a(input logic [3:0] v);
    int n = 0;
    while (bus_a.EN !== v && n < 80) begin
      @(negedge CLK);
      n++;
    end
    check("a_wait_en", 32'(bus_a.EN), 32'(v));
  endtask

  // Monitor for dut_a: per-cycle invariants, grant order, hold length, dead gap.
  initial begin : mon_a
    logic [3:0] prev;
    int   run, gap;
    bit   havep, cur_ok;
    exp_t cur;
    prev = '0; run = 0; gap = 0; havep = 0; cur_ok = 0;
    cur.owner = 0; cur.len = 0; cur.gap = -1;
    forever begin
      @(negedge CLK);
      if (RST_A !== 1'b0) begin
        prev = '0; run = 0; gap = 0; havep = 0; cur_ok = 0;
      end else begin
        check("a_en_xor_nen", 32'(bus_a.EN ^ bus_a.nEN), 32'hF);
        check("a_onehot", 32'($countones(bus_a.EN) <= 1), 32'd1);
        check("a_gnt_eq_en", 32'(bus_a.GNT ^ bus_a.EN), 32'd0);
        check("a_bus_idle", 32'(bus_a.BUS_IDLE), 32'(bus_a.EN == 4'd0));
        if (bus_a.EN != 4'd0 && prev == 4'd0) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++; cur_ok = 0;
            $display("FAIL a_unexpected_grant: got EN=%b want no grant", bus_a.EN);
          end else begin
            cur = sb.pop_front();
            cur_ok = 1;
            check("a_grant_en", 32'(bus_a.EN), 32'd1 << cur.owner);
            check("a_owner", 32'(bus_a.OWNER), 32'(cur.owner));
            if (havep && cur.gap >= 0) check("a_gap", 32'(gap), 32'(cur.gap));
          end
          run = 1;
        end else if (bus_a.EN != 4'd0) begin
          if (bus_a.EN != prev) check("a_no_switch", 32'(bus_a.EN), 32'(prev));
          run++;
        end else begin
          if (prev != 4'd0) begin
            if (cur_ok && cur.len > 0) check("a_hold_len", 32'(run), 32'(cur.len));
            gap = 0;
            havep = 1;
          end
          gap++;
        end
        prev = bus_a.EN;
      end
    end
  end

  initial begin : stim
    int g;
    RST_A = 1'b1; RST_B = 1'b1;
    bus_a.REQ = '0; bus_b.REQ = '0;
    @(negedge CLK); @(negedge CLK);
    check("rst_en",    32'(bus_a.EN),       32'h0);
    check("rst_nen",   32'(bus_a.nEN),      32'hF);
    check("rst_gnt",   32'(bus_a.GNT),      32'h0);
    check("rst_owner", 32'(bus_a.OWNER),    32'h0);
    check("rst_idle",  32'(bus_a.BUS_IDLE), 32'h1);

    // Single requester, then a second one forces hand-off after MAX_HOLD.
    RST_A = 1'b0; bus_a.REQ = 4'b0001; push(0, 8, -1);
    repeat (3) @(negedge CLK);
    bus_a.REQ = 4'b0011; push(1, 8, 1);
    wait_en_a(4'b0010);

    // Everyone requesting: rotation 2,3,0 then owner 1 leaves after one cycle.
    bus_a.REQ = 4'b1111;
    push(2, 8, 1); push(3, 8, 1); push(0, 8, 1); push(1, 1, 1);
    wait_en_a(4'b0001);
    wait_en_a(4'b0010);
    bus_a.REQ = 4'b0100; push(2, 3, 1);

    // Sole requester drops for one cycle: must pass through TURN before regrant.
    wait_en_a(4'b0100);
    repeat (2) @(negedge CLK);
    bus_a.REQ = 4'b0000;
    @(negedge CLK);
    bus_a.REQ = 4'b0100; push(2, -1, 1);
    wait_en_a(4'b0100);
    repeat (12) @(negedge CLK);

    // Async reset mid-OWN, sampled before any clock edge.
    #2 RST_A = 1'b1;
    #1;
    check("mid_rst_en",    32'(bus_a.EN),       32'h0);
    check("mid_rst_nen",   32'(bus_a.nEN),      32'hF);
    check("mid_rst_idle",  32'(bus_a.BUS_IDLE), 32'h1);
    check("mid_rst_owner", 32'(bus_a.OWNER),    32'h0);
    @(negedge CLK); @(negedge CLK);
    RST_A = 1'b0; bus_a.REQ = 4'b1000; push(3, 8, -1);
    wait_en_a(4'b1000);
    bus_a.REQ = 4'b1001; push(0, 1, 1);
    wait_en_a(4'b0001);
    bus_a.REQ = 4'b0000;
    repeat (5) @(negedge CLK);
    check("a_sb_empty", 32'(sb.size()), 32'd0);

    // TURN_CYCLES=3 instance: pointer 0 picks 2 first, then 0 after a 3-cycle gap.
    RST_B = 1'b0; bus_b.REQ = 4'b0101;
    g = 0;
    while (bus_b.EN == 4'd0 && g < 40) begin @(negedge CLK); g++; end
    check("b_first_en",    32'(bus_b.EN),    32'b0100);
    check("b_first_owner", 32'(bus_b.OWNER), 32'd2);
    g = 0;
    while (bus_b.EN != 4'd0 && g < 40) begin @(negedge CLK); g++; end
    g = 0;
    while (bus_b.EN == 4'd0 && g < 20) begin
      check("b_gap_idle", 32'(bus_b.BUS_IDLE), 32'd1);
      check("b_gap_nen",  32'(bus_b.nEN),      32'hF);
      @(negedge CLK);
      g++;
    end
    check("b_gap_len",      32'(g),           32'd3);
    check("b_second_en",    32'(bus_b.EN),    32'b0001);
    check("b_second_owner", 32'(bus_b.OWNER), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
